uart_led7_cmd_ctrl: RTL and testbench
=====================================

// Module: uart_led7_cmd_ctrl
// PURPOSE
//  Command controller between the UART receiver and the 7-segment LED bank of device_top.
//  Parses framed byte commands from the RX byte stream and validates them.
//  Sequences writes into a per-digit display register file.
//  Drives the active-low segment outputs through a hex-to-segment decoder.
// PARAMETERS
//  CLK_FREQ      50      clock frequency, MHz
//  BIT_RATE      115200  UART bit rate, bit/s
//  NUM_DIGITS    4       number of 7-seg digits (1..8)
//  TIMEOUT_BITS  20      inter-byte gap, in bit periods, that aborts a partial frame
// PORTS
//  clk        in   1             system clock
//  resetn     in   1             synchronous reset, active low
//  rx_data    in   8             byte from UART receiver
//  rx_valid   in   1             1-cycle strobe, rx_data valid
//  rx_err     in   1             1-cycle strobe, UART framing/stop-bit error
//  hex        out  7*NUM_DIGITS  segments, active low; digit i = hex[7i+6:7i] = {g,f,e,d,c,b,a}
//  frame_ok   out  1             1-cycle pulse, frame accepted and written
//  frame_err  out  1             1-cycle pulse, frame rejected
// BEHAVIOUR
//  Clocking/reset
//   - One clock (clk); resetn is synchronous, active low.
//   - Reset: FSM=IDLE, every digit = blank, hex = all 1s, frame_ok=0, frame_err=0, timeout counter=0.
//  Frame format
//   - 4 bytes: HDR=0xA5, ADDR, DATA, CHK.
//   - ADDR: 0..NUM_DIGITS-1, or 0xFF = broadcast to all digits.
//   - DATA[3:0]: hex value. DATA[4]=1: blank the digit. DATA[7:5]: ignored.
//   - CHK must equal ADDR ^ DATA.
//  FSM (IDLE, ADDR, DATA, CHK), advances one state per rx_valid
//   - IDLE: byte 0xA5 -> ADDR. Any other byte is ignored, with no error pulse.
//   - ADDR: latch the byte -> DATA. Range is not checked here.
//   - DATA: latch the byte -> CHK.
//   - CHK: always -> IDLE, then:
//       - checksum good and ADDR valid -> write digit(s), frame_ok=1.
//       - otherwise -> frame_err=1, no write.
//  Timing
//   - Digit write and frame_ok/frame_err pulse are registered on the edge that samples CHK.
//   - hex is a combinational decode of the digit registers, so it changes on that same edge.
//   - Latency from CHK strobe: 1 clk.
//  Timeout
//   - Counter limit: T = CLK_FREQ*1e6/BIT_RATE*TIMEOUT_BITS cycles, computed at elaboration.
//   - Counter runs only while not in IDLE. Cleared on every rx_valid and on entry to IDLE.
//   - Reaching T-1: -> IDLE, frame_err pulse.
//  Error and corner cases
//   - rx_err in any non-IDLE state: -> IDLE, frame_err pulse, no write.
//   - rx_err in IDLE: ignored.
//   - rx_err and rx_valid in the same cycle: rx_err wins, the byte is dropped.
//   - rx_valid and timeout expiry in the same cycle: the byte wins, counter cleared.
//   - 0xA5 received in ADDR/DATA/CHK: treated as payload data, no resync.
//   - Back-to-back frames with zero idle cycles are supported.
//   - frame_ok and frame_err are never high together.
//   - resetn low mid-frame: the partial frame is discarded, displays are blanked, no pulse.
// STRUCTURE
//  - Package led7_pkg:
//      - state_t enum (IDLE, ADDR, DATA, CHK)
//      - HDR_BYTE = 8'hA5, ADDR_ALL = 8'hFF
//      - function seg7_code(logic [4:0]) -> logic [6:0], active-low table
//  - Sub-module seg7_decoder: combinational, one instance per digit via generate.
//      - in[4:0] = {blank, val[3:0]}; out[6:0].
//  - Top: FSM, ADDR/DATA holding registers, timeout counter ($clog2(T) bits),
//    digit register file [NUM_DIGITS][4:0], pulse registers.
// TESTING
//  - Drive bytes through UART_intf at 115200 baud, CLK_FREQ=50; 
//    check hex through Leds_intf.
//  - Scenarios:
//   1. Reset release -> hex all 1s, no pulses.
//   2. A5 01 03 02 -> frame_ok. Digit1 = 7'b0110000 ('3'). Other digits stay 7'b1111111.
//   3. A5 02 0A 09 (bad CHK) -> frame_err. hex unchanged.
//      Then A5 05 01 04 (ADDR out of range) -> frame_err, no write.
//   4. A5 FF 08 F7 -> all digits 7'b0000000 ('8').
//      Then A5 FF 10 EF -> all digits blank.
//   5. A5 00, then silence > 20 bit times -> frame_err. FSM back in IDLE.
//      A following good frame A5 00 01 01 -> digit0 = 7'b1111001 ('1').
//   6. resetn pulsed low after A5 00 07 -> no pulse, all digits blank.
//      Next full frame is accepted normally.
//      Also: injected rx_err mid-frame -> frame_err.

Source files
------------

// File: rtl/uart_led7_cmd_ctrl_pkg.sv
// Shared types, framing constants and the active-low 7-segment table for the
// UART-driven LED command controller.
package led7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        CHK  = 2'd3
    } state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] ADDR_ALL = 8'hFF;

    // code = {blank, val[3:0]}; result is {g,f,e,d,c,b,a}, 0 lights a segment
    function automatic logic [6:0] seg7_code(input logic [4:0] code);
        logic [6:0] seg;
        if (code[4]) begin
            seg = 7'b1111111;
        end else begin
            case (code[3:0])
                4'h0: seg = 7'b1000000;
                4'h1: seg = 7'b1111001;
                4'h2: seg = 7'b0100100;
                4'h3: seg = 7'b0110000;
                4'h4: seg = 7'b0011001;
                4'h5: seg = 7'b0010010;
                4'h6: seg = 7'b0000010;
                4'h7: seg = 7'b1111000;
                4'h8: seg = 7'b0000000;
                4'h9: seg = 7'b0010000;
                4'hA: seg = 7'b0001000;
                4'hB: seg = 7'b0000011;
                4'hC: seg = 7'b1000110;
                4'hD: seg = 7'b0100001;
                4'hE: seg = 7'b0000110;
                default: seg = 7'b0001110;
            endcase
        end
        return seg;
    endfunction

endpackage

// File: rtl/uart_led7_cmd_ctrl_seg7_decoder.sv
// Combinational hex-to-segment decoder for one digit, blank bit in in[4].
module seg7_decoder
    import led7_pkg::*;
(
    input  logic [4:0] in,
    output logic [6:0] out
);

    assign out = seg7_code(in);

endmodule

// File: rtl/uart_led7_cmd_ctrl.sv
// Parses A5/ADDR/DATA/CHK byte frames from the UART receiver, writes the
// per-digit display registers and drives the active-low segment bank.
module uart_led7_cmd_ctrl
    import led7_pkg::*;
#(
    parameter int CLK_FREQ     = 50,
    parameter int BIT_RATE     = 115200,
    parameter int NUM_DIGITS   = 4,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic                    rx_err,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic                    frame_ok,
    output logic                    frame_err
);

    localparam int T  = CLK_FREQ * 1000000 / BIT_RATE * TIMEOUT_BITS;
    localparam int CW = $clog2(T);
    localparam logic [CW-1:0] CNT_LAST = CW'(T - 1);
    localparam logic [4:0] DIGIT_BLANK = 5'b10000;

    state_t        state_reg, state_next;
    logic [7:0]    addr_reg, addr_next;
    logic [7:0]    data_reg, data_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          ok_reg, ok_next;
    logic          err_reg, err_next;
    logic          wr_en;
    logic          frame_good;

    logic [4:0]    digit_reg [NUM_DIGITS];

    // The incoming byte is the checksum when this is evaluated in CHK
    assign frame_good = (rx_data == (addr_reg ^ data_reg)) &&
                        ((addr_reg == ADDR_ALL) || (addr_reg < 8'(NUM_DIGITS)));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            cnt_reg   <= '0;
            ok_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
            ok_reg    <= ok_next;
            err_reg   <= err_next;
        end
    end

    // Priority: rx_err drops the byte, a byte beats a simultaneous timeout
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        cnt_next   = '0;
        ok_next    = 1'b0;
        err_next   = 1'b0;
        wr_en      = 1'b0;
        if (state_reg != IDLE) begin
            cnt_next = cnt_reg + 1'b1;
        end
        if (rx_err) begin
            cnt_next = '0;
            if (state_reg != IDLE) begin
                state_next = IDLE;
                err_next   = 1'b1;
            end
        end else if (rx_valid) begin
            cnt_next = '0;
            case (state_reg)
                IDLE: begin
                    if (rx_data == HDR_BYTE) begin
                        state_next = ADDR;
                    end
                end
                ADDR: begin
                    addr_next  = rx_data;
                    state_next = DATA;
                end
                DATA: begin
                    data_next  = rx_data;
                    state_next = CHK;
                end
                default: begin
                    state_next = IDLE;
                    if (frame_good) begin
                        wr_en   = 1'b1;
                        ok_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            endcase
        end else if ((state_reg != IDLE) && (cnt_reg == CNT_LAST)) begin
            state_next = IDLE;
            cnt_next   = '0;
            err_next   = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    digit_reg[gi] <= DIGIT_BLANK;
                end else if (wr_en && ((addr_reg == ADDR_ALL) || (addr_reg == 8'(gi)))) begin
                    digit_reg[gi] <= data_reg[4:0];
                end
            end

            seg7_decoder u_dec (
                .in  (digit_reg[gi]),
                .out (hex[7*gi +: 7])
            );
        end
    endgenerate

    assign frame_ok  = ok_reg;
    assign frame_err = err_reg;

endmodule

// File: tb/tb_uart_led7_cmd_ctrl.sv
// Randomized scoreboard bench for uart_led7_cmd_ctrl: frame outcomes are
// predicted from the frame rules and checked when the DUT pulses.
module tb_uart_led7_cmd_ctrl;

    localparam int ND = 4;
    localparam int T  = 50 * 1000000 / 115200 * 20;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic            rx_err = 1'b0;
    logic [7*ND-1:0] hex;
    logic            frame_ok;
    logic            frame_err;

    uart_led7_cmd_ctrl #(
        .CLK_FREQ     (50),
        .BIT_RATE     (115200),
        .NUM_DIGITS   (ND),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .hex       (hex),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic            ok;
        logic [7*ND-1:0] hex;
    } exp_t;

    exp_t       q[$];
    logic [4:0] mdig [ND];
    int         vectors = 0;
    int         miscompares = 0;

    function automatic logic [6:0] seg_of(input logic [4:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        if (d[4]) return 7'h7F;
        return tbl[d[3:0]];
    endfunction

    function automatic logic [7*ND-1:0] model_hex();
        logic [7*ND-1:0] r;
        for (int i = 0; i < ND; i++) r[7*i +: 7] = seg_of(mdig[i]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_err   = 1'b0;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] c, input int gap);
        logic good;
        good = (c == (a ^ d)) && (a == 8'hFF || a < ND);
        if (good) begin
            for (int i = 0; i < ND; i++)
                if (a == 8'hFF || a == i) mdig[i] = d[4:0];
        end
        q.push_back('{ok: good, hex: model_hex()});
        $display("frame %h %h %h gap=%0d expect %s", a, d, c, gap, good ? "ok" : "err");
        send_byte(8'hA5); idle(gap);
        send_byte(a);     idle(gap);
        send_byte(d);     idle(gap);
        send_byte(c);
    endtask

    task automatic pulse_err();
        rx_err = 1'b1;
        @(posedge clk);
        #1;
        rx_err   = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        idle(n);
        resetn = 1'b1;
        for (int i = 0; i < ND; i++) mdig[i] = 5'b10000;
        check("hex_after_reset", 64'(hex), 64'(model_hex()));
        check("pulses_after_reset", 64'({frame_ok, frame_err}), 64'd0);
    endtask

    always @(negedge clk) begin
        if (resetn && (frame_ok || frame_err)) begin
            exp_t e;
            if (frame_ok && frame_err) check("ok_err_exclusive", 64'd3, 64'd1);
            if (q.size() == 0) begin
                check("unexpected_pulse", 64'({frame_ok, frame_err}), 64'd0);
            end else begin
                e = q.pop_front();
                check("pulse_kind_ok", 64'(frame_ok), 64'(e.ok));
                check("hex_at_pulse", 64'(hex), 64'(e.hex));
            end
        end
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, d, c, b;
        int kind, k;
        for (int i = 0; i < ND; i++) mdig[i] = 5'b10000;
        idle(3);
        do_reset(0);
        check("hex_reset_all_ones", 64'(hex), 64'(28'hFFFFFFF));

        // directed scenarios
        send_frame(8'h01, 8'h03, 8'h02, 0); idle(2);
        check("digit1_is_3", 64'(hex), 64'({7'h7F, 7'h7F, 7'b0110000, 7'h7F}));
        send_frame(8'h02, 8'h0A, 8'h09, 1); idle(2);
        send_frame(8'h05, 8'h01, 8'h04, 0); idle(2);
        send_frame(8'hFF, 8'h08, 8'hF7, 0);
        send_frame(8'hFF, 8'h10, 8'hEF, 0); idle(2);
        check("all_blank_bcast", 64'(hex), 64'(28'hFFFFFFF));

        send_byte(8'hA5); send_byte(8'h00);
        q.push_back('{ok: 1'b0, hex: model_hex()});
        $display("partial A5 00 then silence, expect timeout err");
        idle(T + 10);
        send_frame(8'h00, 8'h01, 8'h01, 0); idle(2);
        check("digit0_is_1", 64'(hex[6:0]), 64'(7'b1111001));

        // byte arriving on the expiry cycle wins
        send_frame(8'h03, 8'h0C, 8'h0F, T - 1); idle(2);

        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h07);
        $display("reset mid-frame, expect no pulse");
        do_reset(2);
        send_frame(8'h02, 8'h0E, 8'h0C, 0); idle(2);

        send_byte(8'hA5); send_byte(8'h01);
        q.push_back('{ok: 1'b0, hex: model_hex()});
        $display("rx_err mid-frame, expect err");
        pulse_err(); idle(2);

        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h05);
        q.push_back('{ok: 1'b0, hex: model_hex()});
        $display("rx_err with CHK byte, expect err, no write");
        rx_data = 8'h07; rx_valid = 1'b1; pulse_err(); idle(2);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                k = $urandom_range(0, 5);
                if (k < 4) a = 8'($urandom_range(0, ND - 1));
                else if (k == 4) a = 8'hFF;
                else a = 8'($urandom_range(ND, 254));
                d = 8'($urandom_range(0, 255));
                c = a ^ d;
                if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
                send_frame(a, d, c, $urandom_range(0, 2));
            end else if (kind == 6) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                $display("junk byte %h in idle", b);
                send_byte(b);
            end else if (kind == 7) begin
                k = $urandom_range(1, 3);
                send_byte(8'hA5);
                for (int j = 1; j < k; j++) send_byte(8'($urandom_range(0, 255)));
                q.push_back('{ok: 1'b0, hex: model_hex()});
                $display("rx_err after %0d bytes, expect err", k);
                pulse_err();
            end else if (kind == 8) begin
                $display("rx_err in idle, expect nothing");
                pulse_err();
            end else begin
                send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
                q.push_back('{ok: 1'b0, hex: model_hex()});
                $display("rx_err with valid CHK byte, expect err");
                rx_data = 8'h01; rx_valid = 1'b1; pulse_err();
            end
            idle($urandom_range(0, 2));
        end

        idle(5);
        check("final_hex", 64'(hex), 64'(model_hex()));
        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
